// File: rtl/tick_scheduler_pkg.sv
// tick_scheduler_pkg: shared state encoding, level limit and level increment helper
package tick_scheduler_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2} state_t;
    localparam logic [1:0] LEVEL_MAX = 2'd3;
    function automatic logic [1:0] level_inc(input logic [1:0] l);
        return (l == LEVEL_MAX) ? l : l + 2'd1;
    endfunction
endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: command pulses in, tick enables and status out
interface tick_scheduler_if;
    logic       start;
    logic       stop;
    logic       pause;
    logic       rate_load;
    logic [1:0] rate_req;
    logic       speed_up;
    logic       tick;
    logic       blink;
    logic [7:0] tick_cnt;
    logic [1:0] level;
    logic       running;
    modport master (
        output start, stop, pause, rate_load, rate_req, speed_up,
        input  tick, blink, tick_cnt, level, running
    );
    modport slave (
        input  start, stop, pause, rate_load, rate_req, speed_up,
        output tick, blink, tick_cnt, level, running
    );
endinterface

// File: rtl/tick_scheduler_period_ctr.sv
// tick_scheduler_period_ctr: modulo counter 0..last, wrap flags the final count while enabled
module tick_scheduler_period_ctr #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic             wrap
);
    logic [CNT_W-1:0] count;
    assign wrap = en && (count == last);
    // count only while enabled; clear wins over counting
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else if (en) count <= wrap ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: start/stop/pause timebase with four rate levels switched at tick boundaries
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int DIV_L0 = 50000000,
    parameter int DIV_L1 = 25000000,
    parameter int DIV_L2 = 12500000,
    parameter int DIV_L3 = 6250000,
    parameter int CNT_W  = 26
) (
    input logic           clk,
    input logic           rst,
    tick_scheduler_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST0 = CNT_W'(DIV_L0 - 1);
    localparam logic [CNT_W-1:0] LAST1 = CNT_W'(DIV_L1 - 1);
    localparam logic [CNT_W-1:0] LAST2 = CNT_W'(DIV_L2 - 1);
    localparam logic [CNT_W-1:0] LAST3 = CNT_W'(DIV_L3 - 1);
    state_t           state, state_nx;
    logic             run_en, clr, wrap, tick;
    logic             req, apply, pend_v;
    logic [1:0]       pend, base, req_lvl, tgt;
    logic [CNT_W-1:0] last;
    // command FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else state <= state_nx;
    end
    // stop beats start beats pause; pause toggles RUN and PAUSE only
    always_comb begin
        state_nx = bus.stop                         ? ST_IDLE  :
                   bus.start                        ? ST_RUN   :
                   (bus.pause && state == ST_RUN)   ? ST_PAUSE :
                   (bus.pause && state == ST_PAUSE) ? ST_RUN   : state;
    end
    // FSM outputs: counter enable/clear and status; no tick while reset is held
    always_comb begin
        run_en      = (state == ST_RUN);
        clr         = bus.stop || bus.start;
        tick        = wrap && !rst;
        bus.running = run_en;
        bus.tick    = tick;
    end
    tick_scheduler_period_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (run_en),
        .last (last),
        .wrap (wrap)
    );
    // rate request decode; changes take effect in IDLE, at a tick, or on stop
    always_comb begin
        base    = pend_v ? pend : bus.level;
        req     = bus.rate_load || bus.speed_up;
        req_lvl = bus.rate_load ? bus.rate_req : level_inc(base);
        tgt     = req ? req_lvl : base;
        apply   = (state == ST_IDLE) || tick || bus.stop;
        last    = (bus.level == 2'd0) ? LAST0 :
                  (bus.level == 2'd1) ? LAST1 :
                  (bus.level == 2'd2) ? LAST2 : LAST3;
    end
    // level in effect and the latest request waiting for a boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.level <= 2'd0;
            pend      <= 2'd0;
            pend_v    <= 1'b0;
        end else if (apply) begin
            bus.level <= tgt;
            pend_v    <= 1'b0;
        end else if (req) begin
            pend      <= req_lvl;
            pend_v    <= 1'b1;
        end
    end
    // blink and tick counter: cleared by a start that is not overridden by stop
    always_ff @(posedge clk) begin
        if (rst || (bus.start && !bus.stop)) begin
            bus.blink    <= 1'b0;
            bus.tick_cnt <= 8'd0;
        end else if (tick) begin
            bus.blink    <= ~bus.blink;
            bus.tick_cnt <= bus.tick_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed checks of tick_scheduler with periods 4,3,2,1
module tb_tick_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    tick_scheduler_if bus ();
    tick_scheduler #(.DIV_L0(4), .DIV_L1(3), .DIV_L2(2), .DIV_L3(1), .CNT_W(26)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.pause = 1'b0;
        bus.rate_load = 1'b0;
        bus.speed_up = 1'b0;
    endtask
    task automatic run_period(input int n, input string tag);
        for (int i = 0; i < n - 1; i++) begin
            chk({tag, "_quiet"}, bus.tick, 1'b0);
            step();
        end
        chk({tag, "_tick"}, bus.tick, 1'b1);
        step();
    endtask
    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.pause = 1'b0;
        bus.rate_load = 1'b0;
        bus.rate_req = 2'd0;
        bus.speed_up = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_tick", bus.tick, 1'b0);
        chk("rst_blink", bus.blink, 1'b0);
        chk("rst_cnt", bus.tick_cnt, 8'd0);
        chk("rst_level", bus.level, 2'd0);
        chk("rst_running", bus.running, 1'b0);
        bus.start = 1'b1;
        step();
        chk("start_running", bus.running, 1'b1);
        run_period(4, "p1");
        chk("p1_cnt", bus.tick_cnt, 8'd1);
        chk("p1_blink", bus.blink, 1'b1);
        run_period(4, "p2");
        chk("p2_cnt", bus.tick_cnt, 8'd2);
        chk("p2_blink", bus.blink, 1'b0);
        run_period(4, "p3");
        chk("p3_cnt", bus.tick_cnt, 8'd3);
        chk("p3_blink", bus.blink, 1'b1);
        step();
        bus.pause = 1'b1;
        step();
        chk("pause_running", bus.running, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("paused_tick", bus.tick, 1'b0);
            step();
        end
        bus.pause = 1'b1;
        chk("resume_cycle_tick", bus.tick, 1'b0);
        step();
        chk("resumed_running", bus.running, 1'b1);
        run_period(2, "resume");
        chk("resume_cnt", bus.tick_cnt, 8'd4);
        chk("resume_blink", bus.blink, 1'b0);
        step();
        bus.rate_load = 1'b1;
        bus.rate_req = 2'd2;
        step();
        chk("rl_level_hold", bus.level, 2'd0);
        chk("rl_c2_tick", bus.tick, 1'b0);
        step();
        chk("rl_c3_tick", bus.tick, 1'b1);
        chk("rl_c3_level", bus.level, 2'd0);
        step();
        chk("rl_level_new", bus.level, 2'd2);
        run_period(2, "l2a");
        run_period(2, "l2b");
        chk("l2_cnt", bus.tick_cnt, 8'd7);
        bus.stop = 1'b1;
        step();
        chk("stop_running", bus.running, 1'b0);
        chk("stop_cnt_held", bus.tick_cnt, 8'd7);
        for (int i = 0; i < 5; i++) begin
            bus.speed_up = 1'b1;
            step();
        end
        chk("su_sat_level", bus.level, 2'd3);
        chk("idle_tick", bus.tick, 1'b0);
        bus.start = 1'b1;
        step();
        chk("l3_cnt_clr", bus.tick_cnt, 8'd0);
        chk("l3_tick", bus.tick, 1'b1);
        for (int i = 0; i < 255; i++) step();
        chk("l3_cnt_255", bus.tick_cnt, 8'd255);
        chk("l3_tick_late", bus.tick, 1'b1);
        step();
        chk("l3_cnt_wrap", bus.tick_cnt, 8'd0);
        chk("l3_blink", bus.blink, 1'b0);
        bus.rate_load = 1'b1;
        bus.rate_req = 2'd0;
        step();
        chk("back_l0_level", bus.level, 2'd0);
        chk("back_l0_cnt", bus.tick_cnt, 8'd1);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        step();
        chk("ss_running", bus.running, 1'b0);
        chk("ss_tick", bus.tick, 1'b0);
        chk("ss_cnt_held", bus.tick_cnt, 8'd1);
        step();
        chk("ss_tick2", bus.tick, 1'b0);
        bus.start = 1'b1;
        step();
        chk("restart_cnt", bus.tick_cnt, 8'd0);
        chk("restart_running", bus.running, 1'b1);
        bus.rate_load = 1'b1;
        bus.rate_req = 2'd1;
        step();
        chk("pend_level_hold", bus.level, 2'd0);
        bus.stop = 1'b1;
        step();
        chk("stop_pend_level", bus.level, 2'd1);
        bus.start = 1'b1;
        step();
        run_period(3, "l1");
        chk("l1_cnt", bus.tick_cnt, 8'd1);
        step();
        step();
        chk("pre_rst_tick", bus.tick, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_cycle_tick", bus.tick, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("rst2_tick", bus.tick, 1'b0);
        chk("rst2_blink", bus.blink, 1'b0);
        chk("rst2_cnt", bus.tick_cnt, 8'd0);
        chk("rst2_level", bus.level, 2'd0);
        chk("rst2_running", bus.running, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_tick", bus.tick, 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
